// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// Module : mem_pkg
// Brief  : Shared FSM state encoding, grant encodings and default widths
//          for the two-port memory arbiter.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_RAM_DEPTH     = 1024;
  localparam int DEF_ADDRESS_WIDTH = $clog2(DEF_RAM_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // One-hot grant vector: bit 0 = requester A, bit 1 = requester B
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_A    = 2'b01;
  localparam logic [1:0] GNT_B    = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// Module : mem_port_arbiter_if
// Brief  : Requester and RAM-side signal bundle for mem_port_arbiter.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
);

  logic                     req_a_ip;
  logic                     req_b_ip;
  logic                     we_a_ip;
  logic                     we_b_ip;
  logic [ADDRESS_WIDTH-1:0] address_a_ip;
  logic [ADDRESS_WIDTH-1:0] address_b_ip;
  logic [DATA_WIDTH-1:0]    data_a_ip;
  logic [DATA_WIDTH-1:0]    data_b_ip;
  logic                     ack_a_op;
  logic                     ack_b_op;
  logic [DATA_WIDTH-1:0]    rdata_op;
  logic                     ram_cs_op;
  logic                     ram_we_op;
  logic                     ram_oe_op;
  logic [ADDRESS_WIDTH-1:0] ram_address_op;
  logic [DATA_WIDTH-1:0]    ram_data_op;
  logic [DATA_WIDTH-1:0]    ram_rdata_ip;
  logic                     busy_op;

  // Arbiter side
  modport slave (
    input  req_a_ip, req_b_ip, we_a_ip, we_b_ip,
    input  address_a_ip, address_b_ip, data_a_ip, data_b_ip,
    input  ram_rdata_ip,
    output ack_a_op, ack_b_op, rdata_op,
    output ram_cs_op, ram_we_op, ram_oe_op, ram_address_op, ram_data_op,
    output busy_op
  );

  // Requesters plus RAM environment
  modport master (
    output req_a_ip, req_b_ip, we_a_ip, we_b_ip,
    output address_a_ip, address_b_ip, data_a_ip, data_b_ip,
    output ram_rdata_ip,
    input  ack_a_op, ack_b_op, rdata_op,
    input  ram_cs_op, ram_we_op, ram_oe_op, ram_address_op, ram_data_op,
    input  busy_op
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// Module : rr_arb2
// Brief  : Two-way round-robin selector; a tie goes to the requester that
//          was not granted last.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req,     // bit 0 = A, bit 1 = B
  input  logic       last_b,  // 1 = B was granted most recently
  output logic [1:0] grant
);

  always_comb begin
    grant = GNT_NONE;
    case (req)
      2'b01:   grant = GNT_A;
      2'b10:   grant = GNT_B;
      2'b11:   grant = last_b ? GNT_A : GNT_B;
      default: grant = GNT_NONE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// Module : mem_port_arbiter
// Brief  : Round-robin arbiter sharing one single-port synchronous RAM
//          between two requesters; all outputs registered.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int RAM_DEPTH     = DEF_RAM_DEPTH,
  parameter int ADDRESS_WIDTH = $clog2(RAM_DEPTH)
)(
  input  logic                clk_ip,
  input  logic                rst_ip,
  mem_port_arbiter_if.slave   bus
);

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     r_last_b;
  logic [1:0]               w_grant;
  logic                     w_start;

  logic                     w_sel_we;
  logic [ADDRESS_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0]    w_sel_data;

  logic                     r_we;
  logic                     r_gnt_b;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic                     r_cs;
  logic                     r_ram_we;
  logic                     r_oe;
  logic                     r_ack_a;
  logic                     r_ack_b;
  logic                     r_busy;

  rr_arb2 u_rr_arb2 (
    .req    ({bus.req_b_ip, bus.req_a_ip}),
    .last_b (r_last_b),
    .grant  (w_grant)
  );

  // Requests are only considered while idle; elsewhere they are ignored
  assign w_start    = (r_state == IDLE) && (w_grant != GNT_NONE);
  assign w_sel_we   = w_grant[1] ? bus.we_b_ip      : bus.we_a_ip;
  assign w_sel_addr = w_grant[1] ? bus.address_b_ip : bus.address_a_ip;
  assign w_sel_data = w_grant[1] ? bus.data_b_ip    : bus.data_a_ip;

  always_ff @(posedge clk_ip or posedge rst_ip) begin
    if (rst_ip) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = ACCESS;
      ACCESS:  w_state_next = r_we ? RESP : WAIT;
      WAIT:    w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Winner's command and the round-robin pointer, latched at grant
  always_ff @(posedge clk_ip or posedge rst_ip) begin
    if (rst_ip) begin
      r_we     <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_last_b <= 1'b1;
    end else if (w_start) begin
      r_we     <= w_sel_we;
      r_gnt_b  <= w_grant[1];
      r_addr   <= w_sel_addr;
      r_data   <= w_sel_data;
      r_last_b <= w_grant[1];
    end
  end

  // Outputs are decoded from the next state so they line up with it
  always_ff @(posedge clk_ip or posedge rst_ip) begin
    if (rst_ip) begin
      r_cs     <= 1'b0;
      r_ram_we <= 1'b0;
      r_oe     <= 1'b0;
      r_ack_a  <= 1'b0;
      r_ack_b  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_cs     <= (w_state_next == ACCESS);
      r_ram_we <= (w_state_next == ACCESS) &&  w_sel_we;
      r_oe     <= (w_state_next == ACCESS) && !w_sel_we;
      r_ack_a  <= (w_state_next == RESP)   && !r_gnt_b;
      r_ack_b  <= (w_state_next == RESP)   &&  r_gnt_b;
      r_busy   <= (w_state_next != IDLE);
    end
  end

  // RAM data is valid during WAIT; hold it until the next read capture
  always_ff @(posedge clk_ip or posedge rst_ip) begin
    if (rst_ip) begin
      r_rdata <= '0;
    end else if (r_state == WAIT) begin
      r_rdata <= bus.ram_rdata_ip;
    end
  end

  assign bus.ack_a_op       = r_ack_a;
  assign bus.ack_b_op       = r_ack_b;
  assign bus.rdata_op       = r_rdata;
  assign bus.ram_cs_op      = r_cs;
  assign bus.ram_we_op      = r_ram_we;
  assign bus.ram_oe_op      = r_oe;
  assign bus.ram_address_op = r_addr;
  assign bus.ram_data_op    = r_data;
  assign bus.busy_op        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// Module : tb_mem_port_arbiter
// Brief  : Directed and random bench for mem_port_arbiter with RAM model
//          and expectation queue.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  typedef struct {
    logic          is_b;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  mem_port_arbiter #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .ADDRESS_WIDTH(AW)) dut (
    .clk_ip (clk),
    .rst_ip (rst),
    .bus    (bus.slave)
  );

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  exp_t          sb_q[$];
  exp_t          mon_e;
  logic [DW-1:0] ram   [DEPTH] = '{default: '0};
  logic [DW-1:0] model [DEPTH] = '{default: '0};
  logic          m_last_b    = 1'b1;
  logic          prev_rd     = 1'b0;
  logic [DW-1:0] exp_last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM: write at the access edge, read data valid the following cycle
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ram_cs_op && bus.ram_we_op) ram[bus.ram_address_op] <= bus.ram_data_op;
    if (bus.ram_cs_op && bus.ram_oe_op) bus.ram_rdata_ip <= ram[bus.ram_address_op];
    else                                bus.ram_rdata_ip <= DW'($urandom);
  end

  // Output monitor: checks every cycle and pops the scoreboard on ack
  always @(negedge clk) begin
    if (rst) begin
      exp_last_rd <= '0;
      prev_rd     <= 1'b0;
    end else begin
      chk("dual_ack", 32'(bus.ack_a_op & bus.ack_b_op), 0);
      chk("we_oe_excl", 32'(bus.ram_we_op & bus.ram_oe_op), 0);
      if (!bus.ram_cs_op) chk("ctl_outside_access", {bus.ram_we_op, bus.ram_oe_op}, 0);
      chk("busy", 32'(bus.busy_op),
          32'(bus.ram_cs_op | bus.ack_a_op | bus.ack_b_op | prev_rd));
      prev_rd <= bus.ram_cs_op & bus.ram_oe_op;
      if (bus.ram_cs_op) begin
        if (sb_q.size() == 0) chk("spurious_access", 1, 0);
        else begin
          chk("acc_we", 32'(bus.ram_we_op), 32'(sb_q[0].we));
          chk("acc_oe", 32'(bus.ram_oe_op), 32'(!sb_q[0].we));
          chk("acc_addr", 32'(bus.ram_address_op), 32'(sb_q[0].addr));
          if (sb_q[0].we) chk("acc_data", 32'(bus.ram_data_op), 32'(sb_q[0].data));
        end
      end
      if (bus.ack_a_op || bus.ack_b_op) begin
        if (sb_q.size() == 0) chk("spurious_ack", 1, 0);
        else begin
          mon_e = sb_q.pop_front();
          chk("ack_who", 32'(bus.ack_b_op), 32'(mon_e.is_b));
          if (!mon_e.we) begin
            chk("rdata", 32'(bus.rdata_op), 32'(mon_e.rdata));
            exp_last_rd <= mon_e.rdata;
          end else begin
            chk("rdata_hold", 32'(bus.rdata_op), 32'(exp_last_rd));
          end
        end
      end
    end
  end

  task automatic push_one(input logic is_b, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_t e;
    e.is_b = is_b; e.we = we; e.addr = addr; e.data = data;
    if (we) model[addr] = data;
    e.rdata = model[addr];
    sb_q.push_back(e);
    m_last_b = is_b;
  endtask

  // One arbitration round: raise the enabled requests in an IDLE cycle,
  // drop each one when its ack is seen, and check both latencies.
  task automatic run(input logic a_en, input logic a_we, input logic [AW-1:0] a_ad,
                     input logic [DW-1:0] a_d,
                     input logic b_en, input logic b_we, input logic [AW-1:0] b_ad,
                     input logic [DW-1:0] b_d);
    logic first_b;
    int   s0, ta, tb, lat1, lat2;
    ta = -1; tb = -1;
    @(negedge clk);
    first_b = (a_en && b_en) ? !m_last_b : b_en;
    if (first_b) push_one(1'b1, b_we, b_ad, b_d);
    else         push_one(1'b0, a_we, a_ad, a_d);
    if (a_en && b_en) begin
      if (first_b) push_one(1'b0, a_we, a_ad, a_d);
      else         push_one(1'b1, b_we, b_ad, b_d);
    end
    bus.req_a_ip = a_en; bus.we_a_ip = a_we; bus.address_a_ip = a_ad; bus.data_a_ip = a_d;
    bus.req_b_ip = b_en; bus.we_b_ip = b_we; bus.address_b_ip = b_ad; bus.data_b_ip = b_d;
    s0 = cyc;
    while ((a_en && ta < 0) || (b_en && tb < 0)) begin
      @(negedge clk);
      if (cyc - s0 > 20) begin
        chk("ack_timeout", 1, 0);
        break;
      end
      if (a_en && ta < 0 && bus.ack_a_op) begin ta = cyc; bus.req_a_ip = 1'b0; end
      if (b_en && tb < 0 && bus.ack_b_op) begin tb = cyc; bus.req_b_ip = 1'b0; end
    end
    bus.req_a_ip = 1'b0;
    bus.req_b_ip = 1'b0;
    lat1 = (first_b ? b_we : a_we) ? 2 : 3;
    chk("latency_first", first_b ? tb - s0 : ta - s0, lat1);
    if (a_en && b_en) begin
      lat2 = lat1 + 1 + ((first_b ? a_we : b_we) ? 2 : 3);
      chk("latency_second", first_b ? ta - s0 : tb - s0, lat2);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {bus.ack_a_op, bus.ack_b_op, bus.ram_cs_op, bus.ram_we_op,
              bus.ram_oe_op, bus.busy_op}, 0);
    chk({tag, "_addr"},  32'(bus.ram_address_op), 0);
    chk({tag, "_data"},  32'(bus.ram_data_op), 0);
    chk({tag, "_rdata"}, 32'(bus.rdata_op), 0);
  endtask

  initial begin
    int            n;
    logic          a_en, b_en;
    logic [AW-1:0] aa, ba;
    bus.req_a_ip = 1'b0; bus.we_a_ip = 1'b0; bus.address_a_ip = '0; bus.data_a_ip = '0;
    bus.req_b_ip = 1'b0; bus.we_b_ip = 1'b0; bus.address_b_ip = '0; bus.data_b_ip = '0;

    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    rst = 1'b0;

    // Write then read back from the other port
    run(1'b1, 1'b1, 10'h010, 8'hA5, 1'b0, 1'b0, '0, '0);
    run(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h010, '0);

    // Contending requesters alternate
    run(1'b1, 1'b1, 10'h020, 8'h11, 1'b1, 1'b1, 10'h021, 8'h22);
    run(1'b1, 1'b0, 10'h021, 8'h00, 1'b1, 1'b0, 10'h020, 8'h00);
    run(1'b1, 1'b1, 10'h030, 8'h33, 1'b1, 1'b0, 10'h030, 8'h00);

    // Top address must not alias onto address zero
    run(1'b1, 1'b1, 10'h3FF, 8'hFF, 1'b0, 1'b0, '0, '0);
    run(1'b1, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, '0, '0);
    run(1'b1, 1'b0, 10'h3FF, 8'h00, 1'b0, 1'b0, '0, '0);

    // Reset in the WAIT cycle of a read aborts it without an ack
    @(negedge clk);
    push_one(1'b1, 1'b0, 10'h3FF, 8'h00);
    bus.req_b_ip = 1'b1; bus.we_b_ip = 1'b0; bus.address_b_ip = 10'h3FF;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    sb_q.delete();
    m_last_b = 1'b1;
    #1 chk_all_zero("reset_in_wait");
    bus.req_b_ip = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run(1'b1, 1'b1, 10'h040, 8'h44, 1'b1, 1'b1, 10'h041, 8'h55);

    // Random traffic
    n = 0;
    while (n < 10000) begin
      a_en = 1'($urandom_range(0, 1));
      b_en = a_en ? 1'($urandom_range(0, 1)) : 1'b1;
      aa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
      ba = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
      run(a_en, 1'($urandom_range(0, 1)), aa, DW'($urandom),
          b_en, 1'($urandom_range(0, 1)), ba, DW'($urandom));
      n += int'(a_en) + int'(b_en);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the RAM word width.
REQ-002 The block SHALL have parameter RAM_DEPTH, default 1024, meaning the number of RAM words.
REQ-003 The block SHALL have parameter ADDRESS_WIDTH, default $clog2(RAM_DEPTH), meaning the RAM address width.
REQ-004 Port clk_ip  input  1  single clock; all logic on posedge.
REQ-005 Port rst_ip  input  1  asynchronous, active-high reset.
REQ-006 Port req_a_ip / req_b_ip  input  1  requester access request, held until that requester's ack.
REQ-007 Port we_a_ip / we_b_ip  input  1  1 = write, 0 = read; stable while req high.
REQ-008 Port address_a_ip / address_b_ip  input  ADDRESS_WIDTH  access address; stable while req high.
REQ-009 Port data_a_ip / data_b_ip  input  DATA_WIDTH  write data; stable while req high.
REQ-010 Port ack_a_op / ack_b_op  output  1  one-cycle completion pulse.
REQ-011 Port rdata_op  output  DATA_WIDTH  read result, valid in the ack cycle of a read.
REQ-012 Port ram_cs_op, ram_we_op, ram_oe_op  output  1 each  RAM chip select, write enable, output enable.
REQ-013 Port ram_address_op  output  ADDRESS_WIDTH  RAM address.
REQ-014 Port ram_data_op  output  DATA_WIDTH  RAM write data.
REQ-015 Port ram_rdata_ip  input  DATA_WIDTH  RAM read data, valid the cycle after the read access cycle.
REQ-016 Port busy_op  output  1  high whenever FSM is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, WAIT, RESP; all outputs registered.
REQ-018 IDLE: if any req high at posedge -> latch winner's we/address/data and grant id -> ACCESS; else stay IDLE.
REQ-019 Arbitration SHALL be round-robin: single req wins; both high -> requester not granted last wins; pointer updates on every grant.
REQ-020 ACCESS (exactly one cycle): ram_cs_op=1, ram_address_op=latched address; write -> ram_we_op=1, ram_oe_op=0, ram_data_op=latched data; read -> ram_we_op=0, ram_oe_op=1.
REQ-021 ACCESS -> RESP for write, ACCESS -> WAIT for read; WAIT captures ram_rdata_ip into rdata_op at its closing edge -> RESP.
REQ-022 RESP: ack of granted requester = 1 for exactly one cycle, other ack 0; RAM controls all 0; -> IDLE.
REQ-023 Latency from req sampled in IDLE to ack: write 2 cycles, read 3 cycles; back-to-back requests add one IDLE cycle (write every 3 cycles, read every 4).
REQ-024 Outside ACCESS ram_cs_op, ram_we_op, ram_oe_op SHALL be 0; ram_we_op and ram_oe_op never both 1.
REQ-025 rdata_op SHALL hold its last value until the next read capture; writes do not alter it.
REQ-026 Requests arriving or dropping while not IDLE SHALL be ignored; a req still high in the IDLE after its own ack SHALL be re-arbitrated as a new access.
REQ-027 Only one requester SHALL ever be granted per access; the other requester's ack stays 0.

Reset
REQ-028 On rst_ip=1, asynchronously: state=IDLE, all acks/RAM controls/busy_op=0, ram_address_op=0, ram_data_op=0, rdata_op=0, round-robin pointer = "B last" (A wins first tie).
REQ-029 Reset mid-access SHALL abort the access with no ack; the aborted requester must re-request.

Structure
REQ-030 State enum (IDLE/ACCESS/WAIT/RESP) and default width constants SHALL live in shared package mem_pkg.
REQ-031 Round-robin selection SHALL be a sub-module rr_arb2 (inputs req pair + pointer, output one-hot grant); FSM and datapath stay in mem_port_arbiter.

Verification
REQ-032 A writes 0xA5 to 0x010 -> ACCESS shows cs=1, we=1, oe=0, address 0x010, data 0xA5; ack_a_op 2 cycles after req sample.
REQ-033 After REQ-032, B reads 0x010 -> ram_oe_op=1 in ACCESS; rdata_op=0xA5 with ack_b_op 3 cycles after req sample.
REQ-034 A and B both request continuously after reset -> grants alternate A,B,A,B; no cycle has both acks high.
REQ-035 A writes 0x3FF (top address) = 0xFF, then reads 0x000 (= 0x00 from model) -> no aliasing; rdata_op correct per scoreboard.
REQ-036 rst_ip asserted during WAIT of a read -> all outputs 0 immediately, no ack; post-reset simultaneous requests grant A first.
REQ-037 Random A/B traffic 10,000 accesses with scoreboard RAM model -> every read matches last write; busy_op matches state != IDLE.
